// File: rtl/sc1602_nibble_if.sv
// sc1602_nibble_if: 4-bit bus driver for an SC1602 / HD44780-style character LCD.
//
// Runs the power-on 4-bit-mode init sequence (nibbles 3,3,3,2) on its own,
// then accepts command/data bytes through a valid/ready handshake. Each byte
// goes out as a high nibble and then a low nibble. Each nibble has a setup
// phase, an lcd_en strobe and a hold phase, and the byte ends with a fixed
// execution wait. The LCD busy flag is never polled.
//
// Ports:
//   sys_clk   - system clock
//   sys_rst   - asynchronous active-high reset
//   in_valid  - upstream byte valid
//   in_ready  - high only in IDLE; a byte transfers on in_valid && in_ready
//   in_rs     - 0 = command, 1 = data
//   in_data   - byte to send
//   lcd_data  - LCD DB7..DB4
//   lcd_rs    - LCD register select
//   lcd_en    - LCD enable strobe
//   init_done - set once the init sequence completes; cleared only by reset
//   state     - current FSM state encoding (debug probe)
module sc1602_nibble_if #(
    parameter int POWERUP_CYC    = 1080000,
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 14,
    parameter int HOLD_CYC       = 2,
    parameter int GAP_CYC        = 27,
    parameter int CMD_WAIT_CYC   = 1080,
    parameter int CLR_WAIT_CYC   = 44280,
    parameter int INIT_WAIT1_CYC = 111000,
    parameter int INIT_WAIT2_CYC = 2700
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       init_done,
    output logic [4:0] state
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_HIGH_CYC, HOLD_CYC)),
                                  max2(max2(GAP_CYC, CMD_WAIT_CYC),
                                       max2(CLR_WAIT_CYC, max2(INIT_WAIT1_CYC, INIT_WAIT2_CYC))));
    localparam int CW = $clog2(MAX_CYC) + 1;

    typedef enum logic [4:0] {
        PWR     = 5'h00,
        I_SETUP = 5'h01,
        I_EN    = 5'h02,
        I_HOLD  = 5'h03,
        I_WAIT  = 5'h04,
        IDLE    = 5'h08,
        H_SETUP = 5'h10,
        H_EN    = 5'h11,
        H_HOLD  = 5'h12,
        GAP     = 5'h13,
        L_SETUP = 5'h14,
        L_EN    = 5'h15,
        L_HOLD  = 5'h16,
        X_WAIT  = 5'h17
    } state_t;

    state_t        cur_state, next_state;
    logic [CW-1:0] cnt;
    logic [1:0]    step, step_n;
    logic          rs_q, rs_n;
    logic [7:0]    data_q, data_n;
    logic          long_wait;
    logic          en_n, ready_n, done_n, lcd_rs_n;
    logic [3:0]    lcd_data_n;

    // The counter is loaded with (length - 1) on entry. A state advances on
    // the cycle where the counter reads zero.
    function automatic logic [CW-1:0] reload(input state_t s, input logic [1:0] st,
                                             input logic clr);
        int d;
        case (s)
            PWR:                      d = POWERUP_CYC;
            I_SETUP, H_SETUP, L_SETUP: d = SETUP_CYC;
            I_EN, H_EN, L_EN:         d = EN_HIGH_CYC;
            I_HOLD, H_HOLD, L_HOLD:   d = HOLD_CYC;
            GAP:                      d = GAP_CYC;
            I_WAIT:                   d = (st == 2'd0) ? INIT_WAIT1_CYC :
                                          (st == 2'd1) ? INIT_WAIT2_CYC : CMD_WAIT_CYC;
            X_WAIT:                   d = clr ? CLR_WAIT_CYC : CMD_WAIT_CYC;
            default:                  d = 1;
        endcase
        return CW'(d - 1);
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);

    always_comb begin
        next_state = cur_state;
        step_n     = step;
        rs_n       = rs_q;
        data_n     = data_q;
        case (cur_state)
            PWR:     if (cnt == '0) next_state = I_SETUP;
            I_SETUP: if (cnt == '0) next_state = I_EN;
            I_EN:    if (cnt == '0) next_state = I_HOLD;
            I_HOLD:  if (cnt == '0) next_state = I_WAIT;
            I_WAIT: begin
                if (cnt == '0) begin
                    if (step == 2'd3) begin
                        next_state = IDLE;
                    end else begin
                        next_state = I_SETUP;
                        step_n     = step + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (in_valid && in_ready) begin
                    next_state = H_SETUP;
                    rs_n       = in_rs;
                    data_n     = in_data;
                end
            end
            H_SETUP: if (cnt == '0) next_state = H_EN;
            H_EN:    if (cnt == '0) next_state = H_HOLD;
            H_HOLD:  if (cnt == '0) next_state = GAP;
            GAP:     if (cnt == '0) next_state = L_SETUP;
            L_SETUP: if (cnt == '0) next_state = L_EN;
            L_EN:    if (cnt == '0) next_state = L_HOLD;
            L_HOLD:  if (cnt == '0) next_state = X_WAIT;
            X_WAIT:  if (cnt == '0) next_state = IDLE;
            default: next_state = PWR;
        endcase
    end

    // Output values are derived from the next state so that the registered
    // pins line up with the state register cycle for cycle.
    always_comb begin
        en_n       = next_state inside {I_EN, H_EN, L_EN};
        ready_n    = (next_state == IDLE);
        done_n     = init_done || (next_state == IDLE);
        lcd_rs_n   = lcd_rs;
        lcd_data_n = lcd_data;
        case (next_state)
            PWR: begin
                lcd_rs_n   = 1'b0;
                lcd_data_n = 4'd0;
            end
            I_SETUP, I_EN, I_HOLD: begin
                lcd_rs_n   = 1'b0;
                lcd_data_n = (step_n == 2'd3) ? 4'd2 : 4'd3;
            end
            H_SETUP, H_EN, H_HOLD, GAP: begin
                lcd_rs_n   = rs_n;
                lcd_data_n = data_n[7:4];
            end
            L_SETUP, L_EN, L_HOLD: begin
                lcd_rs_n   = rs_n;
                lcd_data_n = data_n[3:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cur_state <= PWR;
            // Reset is the entry into PWR, so the counter takes PWR's reload.
            cnt       <= CW'(POWERUP_CYC - 1);
            step      <= '0;
            rs_q      <= 1'b0;
            data_q    <= '0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state)
                cnt <= reload(next_state, step_n, long_wait);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            step      <= step_n;
            rs_q      <= rs_n;
            data_q    <= data_n;
            lcd_en    <= en_n;
            lcd_rs    <= lcd_rs_n;
            lcd_data  <= lcd_data_n;
            in_ready  <= ready_n;
            init_done <= done_n;
        end
    end

    assign state = cur_state;

endmodule
